huffman_decoder: RTL and testbench

- Serial Huffman decoder for the 4-symbol alphabet (A, B, C, D) whose codes are built from the bubble_sort weight ordering.
- Receives a code table and a bit stream under a valid/ready handshake, and emits one 2-bit symbol index per complete codeword.
- Sits at the receive end of the Huffman path, opposite the encoder built on the sorted weights.

---
 rtl/huffman_decoder_if.sv | 23 ++
 rtl/huffman_decoder.sv | 171 +++++++++++++++++
 tb/tb_huffman_decoder.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_decoder_if.sv
// Bit-stream / symbol-stream bundle for huffman_decoder.
//   master : drives bit_in, bit_valid, sym_ready; observes bit_ready,
//            sym_out, sym_valid, dec_err (upstream source + downstream sink)
//   slave  : the decoder side
interface huffman_decoder_if;
    logic       bit_in;
    logic       bit_valid;
    logic       bit_ready;
    logic [1:0] sym_out;
    logic       sym_valid;
    logic       sym_ready;
    logic       dec_err;

    modport master (
        output bit_in, bit_valid, sym_ready,
        input  bit_ready, sym_out, sym_valid, dec_err
    );

    modport slave (
        input  bit_in, bit_valid, sym_ready,
        output bit_ready, sym_out, sym_valid, dec_err
    );
endinterface

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder for a 4-symbol alphabet (A=0, B=1, C=2, D=3).
// A code table (length + right-aligned code per symbol) is latched by
// cfg_load; bits are then shifted in MSB-first and a 2-bit symbol index is
// emitted per complete codeword under a valid/ready handshake.
//
// Ports:
//   CLK, nRST             clock (rising edge), async active-low reset
//   cfg_load              strobe latching code_len_* / code_*
//   code_len_A..D [1:0]   codeword length 1..3, 0 = symbol unused
//   code_A..D     [2:0]   codeword, right-aligned
//   bus (slave)           bit_in/bit_valid/bit_ready, sym_out/sym_valid/
//                         sym_ready, dec_err
//   sym_count             {cnt_D, cnt_C, cnt_B, cnt_A}, only when
//                         HUFFMAN_DECODER_SYM_COUNT_EN is defined
//
// Optional feature macro: HUFFMAN_DECODER_SYM_COUNT_EN
//
// state  | meaning
// UNCFG  | no table loaded, bits refused
// DECODE | shifting bits in, bit_ready=1
// HOLD   | symbol presented, waiting for sym_ready
module huffman_decoder #(
    parameter int MAX_LEN = 3,
    parameter int CNT_W   = 16
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic               cfg_load,
    input  logic [1:0]         code_len_A,
    input  logic [1:0]         code_len_B,
    input  logic [1:0]         code_len_C,
    input  logic [1:0]         code_len_D,
    input  logic [MAX_LEN-1:0] code_A,
    input  logic [MAX_LEN-1:0] code_B,
    input  logic [MAX_LEN-1:0] code_C,
    input  logic [MAX_LEN-1:0] code_D,
`ifdef HUFFMAN_DECODER_SYM_COUNT_EN
    output logic [4*CNT_W-1:0] sym_count,
`endif
    huffman_decoder_if.slave   bus
);

    typedef enum logic [1:0] {UNCFG, DECODE, HOLD} state_t;

    state_t             state, state_n;
    logic [MAX_LEN-1:0] acc, acc_d, acc_n;
    logic [1:0]         cnt, cnt_d, cnt_n;
    logic [1:0]         sym_q, sym_d;
    logic               err_q, err_d;
    logic [1:0]         len_q  [4];
    logic [MAX_LEN-1:0] code_q [4];
    logic [MAX_LEN-1:0] mask;
    logic [3:0]         hit;
    logic [1:0]         hit_idx;

    assign acc_n = {acc[MAX_LEN-2:0], bus.bit_in};
    assign cnt_n = cnt + 2'd1;

    // Only the low cnt_n bits of the shifted accumulator form the candidate.
    always_comb begin
        mask = '1;
        case (cnt_n)
            2'd1:    mask = MAX_LEN'(1);
            2'd2:    mask = MAX_LEN'(3);
            default: mask = '1;
        endcase
    end

    always_comb begin
        hit     = '0;
        hit_idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            hit[i] = (len_q[i] == cnt_n) && ((acc_n & mask) == (code_q[i] & mask));
        end
        // Malformed tables with several hits resolve to the lowest index.
        if (hit[0])      hit_idx = 2'd0;
        else if (hit[1]) hit_idx = 2'd1;
        else if (hit[2]) hit_idx = 2'd2;
        else             hit_idx = 2'd3;
    end

    always_comb begin
        state_n = state;
        acc_d   = acc;
        cnt_d   = cnt;
        sym_d   = sym_q;
        err_d   = 1'b0;
        if (cfg_load) begin
            state_n = DECODE;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state)
                UNCFG: state_n = UNCFG;
                DECODE: begin
                    if (bus.bit_valid) begin
                        if (|hit) begin
                            sym_d   = hit_idx;
                            state_n = HOLD;
                            acc_d   = '0;
                            cnt_d   = '0;
                        end else if (cnt_n == 2'(MAX_LEN)) begin
                            err_d = 1'b1;
                            acc_d = '0;
                            cnt_d = '0;
                        end else begin
                            acc_d = acc_n;
                            cnt_d = cnt_n;
                        end
                    end
                end
                HOLD: begin
                    if (bus.sym_ready) state_n = DECODE;
                end
                default: state_n = UNCFG;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= UNCFG;
            acc   <= '0;
            cnt   <= '0;
            sym_q <= '0;
            err_q <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                len_q[i]  <= '0;
                code_q[i] <= '0;
            end
        end else begin
            state <= state_n;
            acc   <= acc_d;
            cnt   <= cnt_d;
            sym_q <= sym_d;
            err_q <= err_d;
            if (cfg_load) begin
                len_q[0]  <= code_len_A;
                len_q[1]  <= code_len_B;
                len_q[2]  <= code_len_C;
                len_q[3]  <= code_len_D;
                code_q[0] <= code_A;
                code_q[1] <= code_B;
                code_q[2] <= code_C;
                code_q[3] <= code_D;
            end
        end
    end

    assign bus.bit_ready = (state == DECODE);
    assign bus.sym_valid = (state == HOLD);
    assign bus.sym_out   = sym_q;
    assign bus.dec_err   = err_q;

`ifdef HUFFMAN_DECODER_SYM_COUNT_EN
    logic [CNT_W-1:0] cnt_sym [4];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < 4; i++) cnt_sym[i] <= '0;
        end else if (cfg_load) begin
            for (int i = 0; i < 4; i++) cnt_sym[i] <= '0;
        end else if ((state == HOLD) && bus.sym_ready && (cnt_sym[sym_q] != '1)) begin
            cnt_sym[sym_q] <= cnt_sym[sym_q] + 1'b1;
        end
    end

    assign sym_count = {cnt_sym[3], cnt_sym[2], cnt_sym[1], cnt_sym[0]};
`endif

endmodule

// File: tb/tb_huffman_decoder.sv
// Directed bench for huffman_decoder: standard table C=0, A=11, B=100, D=101.
module tb_huffman_decoder;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic       cfg_load = 1'b0;
    logic [1:0] code_len_A = '0, code_len_B = '0, code_len_C = '0, code_len_D = '0;
    logic [2:0] code_A = '0, code_B = '0, code_C = '0, code_D = '0;
`ifdef HUFFMAN_DECODER_SYM_COUNT_EN
    logic [63:0] sym_count;
`endif

    int total   = 0;
    int bad     = 0;
    int err_cnt = 0;

    huffman_decoder_if bus();

    huffman_decoder dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .cfg_load   (cfg_load),
        .code_len_A (code_len_A),
        .code_len_B (code_len_B),
        .code_len_C (code_len_C),
        .code_len_D (code_len_D),
        .code_A     (code_A),
        .code_B     (code_B),
        .code_C     (code_C),
        .code_D     (code_D),
`ifdef HUFFMAN_DECODER_SYM_COUNT_EN
        .sym_count  (sym_count),
`endif
        .bus        (bus)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (bus.dec_err === 1'b1) err_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic load_table(input logic [1:0] la, lb, lc, ld,
                              input logic [2:0] ca, cb, cc, cd);
        code_len_A = la; code_len_B = lb; code_len_C = lc; code_len_D = ld;
        code_A = ca; code_B = cb; code_C = cc; code_D = cd;
        cfg_load = 1'b1;
        @(posedge CLK); #1;
        cfg_load = 1'b0;
    endtask

    task automatic load_std();
        load_table(2'd2, 2'd3, 2'd1, 2'd3, 3'b011, 3'b100, 3'b000, 3'b101);
    endtask

    // Presents one bit, waits (bounded) for bit_ready, lets it be taken,
    // and returns #1 after the accepting edge.
    task automatic send_bit(input logic b);
        int t;
        bus.bit_in    = b;
        bus.bit_valid = 1'b1;
        t = 0;
        while (bus.bit_ready !== 1'b1 && t < 20) begin
            @(posedge CLK); #1;
            t++;
        end
        if (t >= 20) begin
            bad++;
            total++;
            $display("FAIL send_bit_timeout: bit_ready=%b required 1", bus.bit_ready);
        end
        @(posedge CLK); #1;
        bus.bit_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        total++; if (bus.sym_out !== 2'd0)   begin bad++; $display("FAIL rst_sym_out: got %0d want 0", bus.sym_out); end
        total++; if (bus.sym_valid !== 1'b0) begin bad++; $display("FAIL rst_sym_valid: got %b want 0", bus.sym_valid); end
        total++; if (bus.bit_ready !== 1'b0) begin bad++; $display("FAIL rst_bit_ready: got %b want 0", bus.bit_ready); end
        total++; if (bus.dec_err !== 1'b0)   begin bad++; $display("FAIL rst_dec_err: got %b want 0", bus.dec_err); end
        @(negedge CLK); nRST = 1'b1;
        bus.bit_valid = 1'b1;
        repeat (3) @(posedge CLK); #1;
        total++; if (bus.bit_ready !== 1'b0) begin bad++; $display("FAIL uncfg_bit_ready: got %b want 0", bus.bit_ready); end
        bus.bit_valid = 1'b0;
    endtask

    task automatic test_stream();
        logic [2:0] cw [4];
        int         ln [4];
        int         ex [4];
        logic [2:0] w;
        cw = '{3'b000, 3'b011, 3'b100, 3'b101};
        ln = '{1, 2, 3, 3};
        ex = '{2, 0, 1, 3};
        load_std();
        bus.sym_ready = 1'b1;
        err_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            w = cw[k];
            for (int j = ln[k] - 1; j >= 0; j--) begin
                send_bit(w[j]);
                if (j > 0) begin
                    total++; if (bus.sym_valid !== 1'b0) begin bad++; $display("FAIL stream_mid_valid: word %0d got %b want 0", k, bus.sym_valid); end
                end
            end
            total++; if (bus.sym_valid !== 1'b1) begin bad++; $display("FAIL stream_valid: word %0d got %b want 1", k, bus.sym_valid); end
            total++; if (bus.sym_out !== 2'(ex[k])) begin bad++; $display("FAIL stream_sym: word %0d got %0d want %0d", k, bus.sym_out, ex[k]); end
        end
        @(posedge CLK); #1;
        total++; if (bus.sym_valid !== 1'b0) begin bad++; $display("FAIL stream_release: got %b want 0", bus.sym_valid); end
        total++; if (bus.sym_out !== 2'd3)   begin bad++; $display("FAIL stream_sym_hold: got %0d want 3", bus.sym_out); end
        total++; if (err_cnt !== 0)          begin bad++; $display("FAIL stream_no_err: got %0d pulses want 0", err_cnt); end
    endtask

    task automatic test_backpressure();
        load_std();
        bus.sym_ready = 1'b0;
        send_bit(1'b0);
        total++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 2'd2) begin bad++; $display("FAIL bp_first: valid=%b sym=%0d want 1/2", bus.sym_valid, bus.sym_out); end
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge CLK); #1;
            total++;
            if (bus.sym_valid !== 1'b1 || bus.sym_out !== 2'd2 || bus.bit_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold: cycle %0d valid=%b sym=%0d ready=%b want 1/2/0", c, bus.sym_valid, bus.sym_out, bus.bit_ready);
            end
        end
        bus.sym_ready = 1'b1;
        @(posedge CLK); #1;
        total++; if (bus.sym_valid !== 1'b0 || bus.bit_ready !== 1'b1) begin bad++; $display("FAIL bp_release: valid=%b ready=%b want 0/1", bus.sym_valid, bus.bit_ready); end
        @(posedge CLK); #1;
        total++; if (bus.sym_valid !== 1'b0) begin bad++; $display("FAIL bp_partial: valid=%b want 0", bus.sym_valid); end
        @(posedge CLK); #1;
        bus.bit_valid = 1'b0;
        total++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 2'd0) begin bad++; $display("FAIL bp_resume: valid=%b sym=%0d want 1/0", bus.sym_valid, bus.sym_out); end
    endtask

    task automatic test_dec_err();
        load_table(2'd2, 2'd3, 2'd1, 2'd0, 3'b011, 3'b100, 3'b000, 3'b000);
        bus.sym_ready = 1'b1;
        err_cnt = 0;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        total++; if (bus.dec_err !== 1'b1 || bus.sym_valid !== 1'b0) begin bad++; $display("FAIL err_pulse: err=%b valid=%b want 1/0", bus.dec_err, bus.sym_valid); end
        @(posedge CLK); #1;
        total++; if (bus.dec_err !== 1'b0) begin bad++; $display("FAIL err_one_cycle: got %b want 0", bus.dec_err); end
        total++; if (err_cnt !== 1)        begin bad++; $display("FAIL err_count: got %0d want 1", err_cnt); end
        send_bit(1'b0);
        total++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 2'd2) begin bad++; $display("FAIL err_recover: valid=%b sym=%0d want 1/2", bus.sym_valid, bus.sym_out); end
    endtask

    task automatic test_reset_mid();
        load_std();
        bus.sym_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        #2 nRST = 1'b0;
        #1;
        total++;
        if (bus.sym_out !== 2'd0 || bus.sym_valid !== 1'b0 || bus.bit_ready !== 1'b0 || bus.dec_err !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs: sym=%0d valid=%b ready=%b err=%b want 0/0/0/0", bus.sym_out, bus.sym_valid, bus.bit_ready, bus.dec_err);
        end
        @(negedge CLK); nRST = 1'b1;
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b1;
        repeat (3) @(posedge CLK); #1;
        total++; if (bus.bit_ready !== 1'b0 || bus.sym_valid !== 1'b0) begin bad++; $display("FAIL midrst_uncfg: ready=%b valid=%b want 0/0", bus.bit_ready, bus.sym_valid); end
        bus.bit_valid = 1'b0;
        load_std();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        total++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 2'd1) begin bad++; $display("FAIL midrst_reload: valid=%b sym=%0d want 1/1", bus.sym_valid, bus.sym_out); end
    endtask

    task automatic test_cfg_collision();
        bus.sym_ready = 1'b1;
        send_bit(1'b1);
        bus.bit_in    = 1'b1;
        bus.bit_valid = 1'b1;
        code_len_A = 2'd2; code_len_B = 2'd3; code_len_C = 2'd1; code_len_D = 2'd3;
        code_A = 3'b011; code_B = 3'b100; code_C = 3'b000; code_D = 3'b101;
        cfg_load = 1'b1;
        @(posedge CLK); #1;
        cfg_load      = 1'b0;
        bus.bit_valid = 1'b0;
        total++; if (bus.sym_valid !== 1'b0 || bus.bit_ready !== 1'b1) begin bad++; $display("FAIL cfg_collide: valid=%b ready=%b want 0/1", bus.sym_valid, bus.bit_ready); end
        send_bit(1'b0);
        total++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 2'd2) begin bad++; $display("FAIL cfg_acc_clear: valid=%b sym=%0d want 1/2", bus.sym_valid, bus.sym_out); end
    endtask

    task automatic test_priority();
        bus.sym_ready = 1'b1;
        load_table(2'd1, 2'd1, 2'd0, 2'd0, 3'b000, 3'b000, 3'b000, 3'b000);
        send_bit(1'b0);
        total++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 2'd0) begin bad++; $display("FAIL prio_ab: valid=%b sym=%0d want 1/0", bus.sym_valid, bus.sym_out); end
        load_table(2'd0, 2'd1, 2'd1, 2'd1, 3'b000, 3'b001, 3'b001, 3'b001);
        send_bit(1'b1);
        total++; if (bus.sym_valid !== 1'b1 || bus.sym_out !== 2'd1) begin bad++; $display("FAIL prio_bcd: valid=%b sym=%0d want 1/1", bus.sym_valid, bus.sym_out); end
    endtask

`ifdef HUFFMAN_DECODER_SYM_COUNT_EN
    task automatic test_sym_count();
        load_std();
        bus.sym_ready = 1'b1;
        for (int k = 0; k < 3; k++) send_bit(1'b0);
        for (int k = 0; k < 2; k++) begin
            send_bit(1'b1);
            send_bit(1'b1);
        end
        @(posedge CLK); #1;
        total++; if (sym_count !== {16'd0, 16'd3, 16'd0, 16'd2}) begin bad++; $display("FAIL cnt_values: got %h want %h", sym_count, {16'd0, 16'd3, 16'd0, 16'd2}); end
        load_std();
        total++; if (sym_count !== 64'd0) begin bad++; $display("FAIL cnt_clear: got %h want 0", sym_count); end
    endtask
`endif

    initial begin
        bus.bit_in    = 1'b0;
        bus.bit_valid = 1'b0;
        bus.sym_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_dec_err();
        test_reset_mid();
        test_cfg_collision();
        test_priority();
`ifdef HUFFMAN_DECODER_SYM_COUNT_EN
        test_sym_count();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
